// File: rtl/sdram_read_master.sv
// Avalon-MM burst read master: splits a beat-count request into bursts of up to MAX_BURST, one outstanding.
// Returned beats are registered (1-cycle latency); commands hold stable under avm_waitrequest.
module sdram_read_master #(
    parameter int DATA_W    = 128,
    parameter int ADDR_W    = 32,
    parameter int CNT_W     = 16,
    parameter int MAX_BURST = 16
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         read_start,
    input  logic [ADDR_W-1:0]            read_addr,
    input  logic [CNT_W-1:0]             read_cnt,
    output logic                         read_valid,
    output logic [DATA_W-1:0]            read_data,
    output logic                         read_done,
    output logic                         busy,
    output logic [ADDR_W-1:0]            avm_address,
    output logic                         avm_read,
    output logic [$clog2(MAX_BURST):0]   avm_burstcount,
    input  logic                         avm_waitrequest,
    input  logic [DATA_W-1:0]            avm_readdata,
    input  logic                         avm_readdatavalid
);

    localparam int BC_W = $clog2(MAX_BURST) + 1;
    localparam logic [ADDR_W-1:0] BEAT_BYTES = ADDR_W'(DATA_W / 8);

    typedef enum logic [1:0] {S_IDLE, S_CMD, S_DATA, S_DONE} state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [CNT_W-1:0]    rem_q, rem_d;
    logic [BC_W-1:0]     beats_q, beats_d;
    logic [BC_W-1:0]     blen_q, blen_d;
    logic                rvalid_q, rvalid_d;
    logic [DATA_W-1:0]   rdata_q, rdata_d;
    logic [BC_W-1:0]     bc_w;

    assign bc_w = (rem_q > CNT_W'(MAX_BURST)) ? BC_W'(MAX_BURST) : BC_W'(rem_q);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= S_IDLE;
            addr_q   <= '0;
            rem_q    <= '0;
            beats_q  <= '0;
            blen_q   <= '0;
            rvalid_q <= 1'b0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            addr_q   <= addr_d;
            rem_q    <= rem_d;
            beats_q  <= beats_d;
            blen_q   <= blen_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        addr_d   = addr_q;
        rem_d    = rem_q;
        beats_d  = beats_q;
        blen_d   = blen_q;
        rvalid_d = 1'b0;
        rdata_d  = rdata_q;
        case (state_q)
            S_IDLE: begin
                if (read_start) begin
                    addr_d  = read_addr;
                    rem_d   = read_cnt;
                    state_d = (read_cnt == '0) ? S_DONE : S_CMD;
                end
            end
            S_CMD: begin
                if (!avm_waitrequest) begin
                    beats_d = bc_w;
                    blen_d  = bc_w;
                    state_d = S_DATA;
                end
            end
            S_DATA: begin
                // Burst exhausted with nothing remaining: wait out the registered last beat first.
                if (beats_q == '0) begin
                    state_d = S_DONE;
                end else if (avm_readdatavalid) begin
                    rvalid_d = 1'b1;
                    rdata_d  = avm_readdata;
                    beats_d  = beats_q - BC_W'(1);
                    rem_d    = rem_q - CNT_W'(1);
                    if (beats_q == BC_W'(1)) begin
                        addr_d = addr_q + ADDR_W'(blen_q) * BEAT_BYTES;
                        if (rem_q != CNT_W'(1)) begin
                            state_d = S_CMD;
                        end
                    end
                end
            end
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        avm_read       = 1'b0;
        avm_address    = '0;
        avm_burstcount = '0;
        busy           = 1'b0;
        read_done      = 1'b0;
        case (state_q)
            S_CMD: begin
                avm_read       = 1'b1;
                avm_address    = addr_q;
                avm_burstcount = bc_w;
                busy           = 1'b1;
            end
            S_DATA:  busy = 1'b1;
            S_DONE: begin
                busy      = 1'b1;
                read_done = 1'b1;
            end
            default: ;
        endcase
    end

    assign read_valid = rvalid_q;
    assign read_data  = rdata_q;

endmodule
